instr_fetch: RTL

- Fetch sequencer directly upstream of the instruction register (IR).
- Holds the fetch program counter, issues synchronous reads to instruction memory and captures the returned 16-bit word.
- Presents the word plus a one-cycle load strobe that drives the IR write enable, then waits for the execute stage to finish before fetching the next word.
- Handles sequential increment, taken-branch redirect and halt.

---
 rtl/instr_fetch.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch sequencer that sits directly in front of the instruction register.
// It keeps the fetch program counter and issues one synchronous read per
// instruction to instruction memory. MEM_LAT cycles later it captures the
// returned word and presents it with a one-cycle IR load strobe. It then
// waits for the execute stage before choosing the next address: sequential,
// branch target, or halt.
//
// Ports:
//   clk        in   system clock; all state changes on the rising edge
//   reset      in   asynchronous, active-low; clears all state
//   start      in   begin fetching (only looked at while idle)
//   exec_done  in   execute stage finished (only looked at in EXEC)
//   br_taken   in   with exec_done: next fetch address is br_target
//   br_target  in   branch destination
//   halt       in   with exec_done: stop fetching (wins over br_taken)
//   mem_data   in   instruction memory read data
//   mem_addr   out  instruction memory address (registered)
//   mem_rd     out  read strobe, high for exactly one cycle per fetch
//   ir_load    out  one-cycle IR write enable
//   ir_data    out  fetched instruction word
//   pc         out  address of the word on ir_data
//   busy       out  high while a fetch/execute cycle is in progress
//   halted     out  high once halted; only reset leaves this state
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int                 ADDR_W   = 16,
    parameter int                 MEM_LAT  = 1,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              exec_done,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt,
    input  logic [15:0]       mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              ir_load,
    output logic [15:0]       ir_data,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LOAD,
        S_EXEC,
        S_HALTED
    } state_t;

    // Final WAIT count: WAIT lasts MEM_LAT cycles, and the counter starts at 0.
    localparam logic [2:0]        LAST_CNT = 3'(MEM_LAT - 1);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q,   mem_rd_d;
    logic              ir_load_q,  ir_load_d;
    logic [15:0]       ir_data_q,  ir_data_d;
    logic [ADDR_W-1:0] pc_q,       pc_d;
    logic              busy_q,     busy_d;
    logic              halted_q,   halted_d;
    logic [2:0]        cnt_q,      cnt_d;
    logic [ADDR_W-1:0] next_pc;

    // All outputs are registered. Each output's value for the next state is
    // therefore set on the transition into that state.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        ir_load_d  = 1'b0;
        ir_data_d  = ir_data_q;
        pc_d       = pc_q;
        busy_d     = busy_q;
        halted_d   = halted_q;
        cnt_d      = cnt_q;
        next_pc    = br_taken ? br_target : (fetch_pc_q + PC_ONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ADDR;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = fetch_pc_q;
                    busy_d     = 1'b1;
                end
            end
            S_ADDR: begin
                state_d = S_WAIT;
                cnt_d   = 3'd0;
            end
            S_WAIT: begin
                // The word read in ADDR is valid on mem_data during the last WAIT cycle.
                if (cnt_q == LAST_CNT) begin
                    state_d   = S_LOAD;
                    ir_data_d = mem_data;
                    pc_d      = fetch_pc_q;
                    ir_load_d = 1'b1;
                    cnt_d     = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_LOAD: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) begin
                    if (halt) begin
                        state_d  = S_HALTED;
                        busy_d   = 1'b0;
                        halted_d = 1'b1;
                    end else begin
                        state_d    = S_ADDR;
                        fetch_pc_d = next_pc;
                        mem_addr_d = next_pc;
                        mem_rd_d   = 1'b1;
                    end
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register. Reset returns to IDLE immediately. Any read that is
    // still in flight is simply never captured.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_rd_q   <= 1'b0;
            ir_load_q  <= 1'b0;
            ir_data_q  <= 16'h0000;
            pc_q       <= RESET_PC;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            ir_load_q  <= ir_load_d;
            ir_data_q  <= ir_data_d;
            pc_q       <= pc_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign ir_load  = ir_load_q;
    assign ir_data  = ir_data_q;
    assign pc       = pc_q;
    assign busy     = busy_q;
    assign halted   = halted_q;

endmodule
